// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// The optional watchdog is enabled with the WB_ARB_TIMEOUT_EN macro.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_TIMEOUT
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: first requester above last_grant.
// Part of wb_arbiter; unaffected by WB_ARB_TIMEOUT_EN.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [N-1:0]     onehot;
    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N);
            if (!valid && req[cand]) begin
                onehot[cand] = 1'b1;
                valid        = 1'b1;
            end
        end
        idx = IDX_W'(onehot_to_idx(8'(onehot)));
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter holding grant for a whole cyc window.
// Define WB_ARB_TIMEOUT_EN to add the unacknowledged-transfer watchdog.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            wb_clk_i,
    input  logic                            rst_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
    input  logic [NUM_MASTERS-1:0]          m_wr_en_i,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byte_en_i,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    output logic [ADDR_W-1:0]               wb_addr_o,
    output logic [DATA_W-1:0]               wb_wdata_o,
    output logic                            wb_wr_en_o,
    output logic [DATA_W/8-1:0]             wb_byte_en_o,
    output logic                            wb_stb_o,
    output logic                            wb_cyc_o,
    input  logic [DATA_W-1:0]               wb_rdata_i,
    input  logic                            wb_ack_i,
    output logic [NUM_MASTERS-1:0]          gnt_o
);

    localparam int N     = NUM_MASTERS;
    localparam int IDX_W = $clog2(N);
    localparam int BE_W  = DATA_W / 8;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, last_q;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    wb_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (m_cyc_i),
        .last_grant (last_q),
        .idx        (pick_idx),
        .valid      (pick_valid)
    );

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N - 1);
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && pick_valid) begin
                grant_q <= pick_idx;
                last_q  <= pick_idx;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             stalled;
    logic             expire;

    assign stalled = m_stb_i[grant_q] && !wb_ack_i;
    assign expire  = stalled && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q != ARB_BUSY || state_d != ARB_BUSY || wb_ack_i) begin
            cnt_q <= '0;
        end else if (stalled) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, ERR_RDATA};
`endif

    always_comb begin
        state_d      = state_q;
        gnt_o        = '0;
        m_ack_o      = '0;
        m_err_o      = '0;
        m_rdata_o    = '0;
        wb_cyc_o     = 1'b0;
        wb_stb_o     = 1'b0;
        wb_addr_o    = '0;
        wb_wdata_o   = '0;
        wb_wr_en_o   = 1'b0;
        wb_byte_en_o = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) state_d = ARB_BUSY;
            end
            ARB_BUSY: begin
                gnt_o[grant_q]   = 1'b1;
                wb_cyc_o         = m_cyc_i[grant_q];
                wb_stb_o         = m_stb_i[grant_q];
                wb_addr_o        = m_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
                wb_wdata_o       = m_wdata_i[int'(grant_q)*DATA_W +: DATA_W];
                wb_wr_en_o       = m_wr_en_i[grant_q];
                wb_byte_en_o     = m_byte_en_i[int'(grant_q)*BE_W +: BE_W];
                m_ack_o[grant_q] = wb_ack_i;
                m_rdata_o        = wb_rdata_i;
                if (!m_cyc_i[grant_q]) begin
                    state_d = ARB_IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (expire) begin
                    m_err_o[grant_q] = 1'b1;
                    m_rdata_o        = DATA_W'(ERR_RDATA);
                    state_d          = ARB_TIMEOUT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            // Slave cycle is dropped; wait for the requester to give up.
            ARB_TIMEOUT: begin
                gnt_o[grant_q] = 1'b1;
                if (!m_cyc_i[grant_q]) state_d = ARB_IDLE;
            end
`endif
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus random traffic
// checked every cycle against a bus-ownership model.
module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*32-1:0] m_addr, m_wdata;
    logic [N*4-1:0]  m_be;
    logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
    logic [31:0]     m_rdata_o, wb_addr_o, wb_wdata_o;
    logic            wb_wr_en_o, wb_stb_o, wb_cyc_o;
    logic [3:0]      wb_byte_en_o;
    logic [31:0]     wb_rdata;
    logic            wb_ack;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i     (clk),
        .rst_i        (rst),
        .m_cyc_i      (m_cyc),
        .m_stb_i      (m_stb),
        .m_addr_i     (m_addr),
        .m_wdata_i    (m_wdata),
        .m_wr_en_i    (m_we),
        .m_byte_en_i  (m_be),
        .m_ack_o      (m_ack_o),
        .m_err_o      (m_err_o),
        .m_rdata_o    (m_rdata_o),
        .wb_addr_o    (wb_addr_o),
        .wb_wdata_o   (wb_wdata_o),
        .wb_wr_en_o   (wb_wr_en_o),
        .wb_byte_en_o (wb_byte_en_o),
        .wb_stb_o     (wb_stb_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_rdata_i   (wb_rdata),
        .wb_ack_i     (wb_ack),
        .gnt_o        (gnt_o)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the bus (-1 = nobody), round-robin pointer,
    // stalled-cycle count and whether the owner was cut off.
    int owner = -1;
    int ptr   = N - 1;
    int stall = 0;
    bit tmo   = 1'b0;

    function automatic bit err_due();
        return TMO_EN && owner >= 0 && !tmo && m_cyc[owner] &&
               m_stb[owner] && !wb_ack && stall == TO - 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            owner = -1;
            ptr   = N - 1;
            stall = 0;
            tmo   = 1'b0;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && m_cyc[(ptr + k) % N]) owner = (ptr + k) % N;
            end
            if (owner >= 0) ptr = owner;
        end else if (!m_cyc[owner]) begin
            owner = -1;
            stall = 0;
            tmo   = 1'b0;
        end else if (!tmo && TMO_EN) begin
            if (err_due()) begin
                tmo   = 1'b1;
                stall = 0;
            end else if (wb_ack) begin
                stall = 0;
            end else if (m_stb[owner]) begin
                stall++;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg, ea, ee;
        logic [31:0]  eaddr, edata, erd;
        logic [3:0]   ebe;
        logic         ecyc, estb, ewe;
        if (run) begin
            eg = '0; ea = '0; ee = '0;
            eaddr = '0; edata = '0; ebe = '0; erd = wb_rdata;
            ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
            if (owner >= 0) begin
                eg[owner] = 1'b1;
                if (!tmo) begin
                    ecyc      = m_cyc[owner];
                    estb      = m_stb[owner];
                    ewe       = m_we[owner];
                    eaddr     = m_addr[owner*32 +: 32];
                    edata     = m_wdata[owner*32 +: 32];
                    ebe       = m_be[owner*4 +: 4];
                    ea[owner] = wb_ack;
                    if (err_due()) begin
                        ee[owner] = 1'b1;
                        erd       = 32'hDEAD_BEEF;
                    end
                end
            end
            check("gnt", 64'(gnt_o), 64'(eg));
            check("wb_cyc", 64'(wb_cyc_o), 64'(ecyc));
            check("wb_stb", 64'(wb_stb_o), 64'(estb));
            check("wb_we", 64'(wb_wr_en_o), 64'(ewe));
            check("wb_addr", 64'(wb_addr_o), 64'(eaddr));
            check("wb_wdata", 64'(wb_wdata_o), 64'(edata));
            check("wb_be", 64'(wb_byte_en_o), 64'(ebe));
            check("m_ack", 64'(m_ack_o), 64'(ea));
            check("m_err", 64'(m_err_o), 64'(ee));
            if (ea != 0 || ee != 0) check("m_rdata", 64'(m_rdata_o), 64'(erd));
        end
    end

    task automatic clear();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_addr = '0; m_wdata = '0; m_be = '0;
        wb_ack = 1'b0; wb_rdata = '0;
    endtask

    task automatic randomize_inputs();
        for (int m = 0; m < N; m++) begin
            if ($urandom_range(0, 4) == 0) m_cyc[m] = ~m_cyc[m];
            m_stb[m]            = 1'($urandom_range(0, 1));
            m_we[m]             = 1'($urandom_range(0, 1));
            m_addr[m*32 +: 32]  = $urandom;
            m_wdata[m*32 +: 32] = $urandom;
            m_be[m*4 +: 4]      = 4'($urandom);
        end
        wb_ack   = ($urandom_range(0, 2) == 0);
        wb_rdata = $urandom;
        rst      = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        rst = 1'b1;
        clear();
        repeat (2) tick();
        run = 1'b1;
        @(negedge clk);
        check("rst_gnt", 64'(gnt_o), 64'h0);
        check("rst_cyc", 64'(wb_cyc_o), 64'h0);
        check("rst_ack", 64'(m_ack_o), 64'h0);
        tick();
        rst = 1'b0;

        // Master 0 write, slave acks on the third granted cycle.
        tick();
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
        m_addr[31:0] = 32'h0F00_0010; m_wdata[31:0] = 32'h1234_5678;
        m_be[3:0] = 4'hF; m_addr[63:32] = 32'h5555_0000;
        tick();
        @(negedge clk);
        check("t1_cyc", 64'(wb_cyc_o), 64'h1);
        check("t1_addr", 64'(wb_addr_o), 64'h0F00_0010);
        check("t1_wdata", 64'(wb_wdata_o), 64'h1234_5678);
        check("t1_gnt", 64'(gnt_o), 64'h1);
        tick();
        tick();
        wb_ack = 1'b1;
        @(negedge clk);
        check("t1_ack", 64'(m_ack_o), 64'h1);
        tick();
        wb_ack = 1'b0; m_cyc = '0; m_stb = '0;
        @(negedge clk);
        check("t1_ack_end", 64'(m_ack_o), 64'h0);
        repeat (2) tick();

        // Master 1 read returning CAFE_0001.
        m_cyc = 2'b10; m_stb = 2'b10; m_we = '0;
        tick();
        wb_rdata = 32'hCAFE_0001; wb_ack = 1'b1;
        @(negedge clk);
        check("t4_rdata", 64'(m_rdata_o), 64'hCAFE_0001);
        check("t4_ack", 64'(m_ack_o), 64'h2);
        tick();
        clear();
        repeat (2) tick();

        // Both masters, four transactions each: strict alternation.
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            wb_ack = 1'b1;
            @(negedge clk);
            check("alt_gnt", 64'(gnt_o), 64'(1 << (k % 2)));
            check("alt_ack", 64'(m_ack_o), 64'(1 << (k % 2)));
            tick();
            wb_ack = 1'b0;
            m_cyc[k % 2] = 1'b0;
            tick();
            m_cyc[k % 2] = 1'b1;
            @(negedge clk);
            check("alt_bubble", 64'(gnt_o), 64'h0);
        end
        tick();
        clear();
        repeat (3) tick();

        // Master 1 keeps cyc for three reads while master 0 waits.
        m_cyc = 2'b10;
        tick();
        tick();
        m_cyc = 2'b11; m_stb = 2'b01;
        for (int r = 0; r < 3; r++) begin
            m_stb[1] = 1'b1; wb_ack = 1'b1; wb_rdata = 32'h100 + r;
            @(negedge clk);
            check("hold_gnt", 64'(gnt_o), 64'h2);
            check("hold_rdata", 64'(m_rdata_o), 64'(32'h100 + r));
            tick();
            m_stb[1] = 1'b0; wb_ack = 1'b0;
            @(negedge clk);
            check("hold_gnt2", 64'(gnt_o), 64'h2);
            tick();
        end
        m_cyc[1] = 1'b0;
        tick();
        @(negedge clk);
        check("hold_bubble", 64'(gnt_o), 64'h0);
        tick();
        @(negedge clk);
        check("hold_next", 64'(gnt_o), 64'h1);
        clear();
        repeat (3) tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never acks master 1.
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int s = 1; s <= TO; s++) begin
            tick();
            @(negedge clk);
            check("to_err", 64'(m_err_o), (s == TO) ? 64'h2 : 64'h0);
            if (s == TO) check("to_rdata", 64'(m_rdata_o), 64'hDEAD_BEEF);
        end
        tick();
        @(negedge clk);
        check("to_cyc_low", 64'(wb_cyc_o), 64'h0);
        check("to_gnt", 64'(gnt_o), 64'h2);
        m_cyc[1] = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("to_next", 64'(gnt_o), 64'h1);
        clear();
        repeat (3) tick();
`endif

        // Reset in the middle of a master 1 cycle.
        m_cyc = 2'b10; m_stb = 2'b10;
        m_addr[63:32] = 32'hABCD_0000;
        tick();
        @(negedge clk);
        check("mr_gnt", 64'(gnt_o), 64'h2);
        tick();
        rst = 1'b1; m_cyc = 2'b11; m_stb = 2'b11; wb_ack = 1'b1;
        tick();
        rst = 1'b0; wb_ack = 1'b0;
        @(negedge clk);
        check("mr_gnt0", 64'(gnt_o), 64'h0);
        check("mr_cyc0", 64'(wb_cyc_o), 64'h0);
        check("mr_addr0", 64'(wb_addr_o), 64'h0);
        check("mr_ack0", 64'(m_ack_o), 64'h0);
        tick();
        @(negedge clk);
        check("mr_first", 64'(gnt_o), 64'h1);
        clear();
        repeat (2) tick();

        repeat (4000) begin
            tick();
            randomize_inputs();
        end
        tick();
        @(negedge clk);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter that shares one Wishbone master port between `NUM_MASTERS` requesters, e.g. the instruction-side and data-side OBI-to-Wishbone bridges feeding the I2C and pinmux peripheral bus. Grant is held for a whole Wishbone cycle, from `cyc` rising to `cyc` falling, so multi-transfer transactions are never interleaved. An optional watchdog terminates transfers that a slave never acknowledges.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of requesters, range 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, a multiple of 8.
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles, used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `wb_clk_i`  in  1  Single clock.
- `rst_i`  in  1  Reset, synchronous, active-high.
- `m_cyc_i`  in  N  Per-master cycle.
- `m_stb_i`  in  N  Per-master strobe.
- `m_addr_i`  in  N*ADDR_W  Packed addresses; master k occupies slice k.
- `m_wdata_i`  in  N*DATA_W  Packed write data.
- `m_wr_en_i`  in  N  Per-master write enable.
- `m_byte_en_i`  in  N*DATA_W/8  Packed byte enables.
- `m_ack_o`  out  N  Ack routed to the granted master only.
- `m_err_o`  out  N  Timeout error pulse.
- `m_rdata_o`  out  DATA_W  Slave read data, broadcast to all masters; valid only with that master's ack or err.
- `wb_addr_o`, `wb_wdata_o`, `wb_wr_en_o`, `wb_byte_en_o`, `wb_stb_o`, `wb_cyc_o`  out  Shared slave-side bus.
- `wb_rdata_i`  in  DATA_W  Slave read data.
- `wb_ack_i`  in  1  Slave acknowledge.
- `gnt_o`  out  N  One-hot current grant, for observation.

## Operation
States:
- `ARB_IDLE`
  - Bus outputs are 0.
  - If any `m_cyc_i` is high, pick the first requester searching upward from `last_grant+1`, wrapping modulo N.
  - Register the pick into `grant` and `last_grant`, then go to `ARB_BUSY`.
- `ARB_BUSY`
  - Slave outputs mirror the granted master combinationally: `wb_cyc_o=m_cyc_i[g]`, `wb_stb_o=m_stb_i[g]`, and address, data, we and byte enables from slice g.
  - `m_ack_o[g]=wb_ack_i`; all other ack bits are 0.
  - When `m_cyc_i[g]` falls, go to `ARB_IDLE`.
- `ARB_TIMEOUT`, only with the macro
  - `wb_cyc_o` and `wb_stb_o` are forced to 0.
  - Stay here until `m_cyc_i[g]` falls, then go to `ARB_IDLE`.

Other rules:
- Requests from non-granted masters are ignored; they receive no ack and no err, and simply wait.
- `wb_ack_i` arriving while in `ARB_IDLE` is ignored.
- The slave sees the strobe of the granted master exactly. The arbiter does not reorder, buffer or retime transfers.

## Timing
- Reset values:
  - State is `ARB_IDLE`, `grant=0`, `last_grant=N-1`, so master 0 has first priority after reset.
  - `gnt_o=0`, all `m_ack_o`/`m_err_o` are 0, all `wb_*_o` are 0, timeout counter is 0.
- Reset asserted mid-transfer: on the next edge all outputs are 0 and the open slave cycle is abandoned.
- Grant latency:
  - `m_cyc_i` high at edge n gives `wb_cyc_o` high after edge n+1.
  - There is one idle bubble cycle between consecutive grants: `m_cyc_i[g]` falls, the next cycle is `ARB_IDLE`, and the new grant is visible one cycle later.
- Ack path is combinational, with zero added latency.
- Simultaneous requests: round-robin order is strict. With all masters requesting continuously, grants cycle 0,1,…,N-1,0.
- A master that drops `cyc` in the same cycle it is granted causes a BUSY→IDLE transition with no slave transfer.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A counter increments every `ARB_BUSY` cycle with `wb_stb_o` high and `wb_ack_i` low, and clears on ack or on leaving `ARB_BUSY`.
  - When the count reaches `TIMEOUT_CYCLES`, pulse `m_err_o[g]` for one cycle, drive `m_rdata_o=ERR_RDATA` in that cycle, and enter `ARB_TIMEOUT`.
- Undefined:
  - No counter and no `ARB_TIMEOUT` state.
  - `m_err_o` is tied to 0.
  - A hung slave holds the grant indefinitely.

## Structure
- Package `wb_arb_pkg`:
  - State enum `arb_state_e`.
  - Constant `ERR_RDATA = 32'hDEAD_BEEF`.
  - Function `onehot_to_idx`.
- Sub-module `wb_rr_pick`:
  - Combinational round-robin selector.
  - Inputs: request vector and `last_grant`. Outputs: index and valid.

## Test plan
- Reset, then master 0 writes addr `0x0F00_0010`, data `0x1234_5678`, and the slave acks after 3 cycles. Expect `wb_cyc_o` one cycle after the request, slave-side fields to match, `m_ack_o=2'b01` for one cycle, and no bus activity from master 1.
- Both masters assert `cyc` in the same cycle, for 4 back-to-back transactions each. Expect grants alternating 0,1,0,1,… with exactly one `ARB_IDLE` bubble between them.
- Master 1 holds `cyc` across 3 strobed reads while master 0 is requesting. Expect all 3 reads to complete on master 1 before `gnt_o` becomes `2'b01`.
- Read returning `0xCAFE_0001` to master 1. Expect `m_rdata_o=0xCAFE_0001` with `m_ack_o=2'b10`, and `m_ack_o[0]=0` throughout.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, the slave never acks. Expect `m_err_o[g]` pulsed on the 8th stalled cycle with `m_rdata_o=0xDEAD_BEEF`, `wb_cyc_o` low the next cycle, and the next master granted after the requester drops `cyc`.
- Assert `rst_i` mid-transfer. Expect all outputs 0 on the next edge, and master 0 granted first afterwards.
